nn_line_upscaler: RTL and testbench

NN_LINE_UPSCALER -- requirements
Module: nn_line_upscaler

---
 rtl/upscale_pkg.sv | 20 ++
 rtl/line_buf_2bank.sv | 41 ++++
 rtl/nn_line_upscaler.sv | 221 ++++++++++++++++++++++
 tb/tb_nn_line_upscaler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upscale_pkg.sv
// Shared state type, default geometry and width helper for the nearest-neighbour line upscaler.
package upscale_pkg;

  localparam int unsigned DefImgW  = 384;
  localparam int unsigned DefImgH  = 216;
  localparam int unsigned DefScale = 3;
  localparam int unsigned DefPixW  = 24;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StEmit    = 2'd1,
    StAdvance = 2'd2
  } emit_state_e;

  // Width of a counter that must reach max_val; a constant-zero counter still gets one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/line_buf_2bank.sv
// Two-bank row store: one write port, one read port with a registered (1-cycle) read.
module line_buf_2bank #(
  parameter int unsigned Depth = 384,
  parameter int unsigned PixW  = 24,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic             wr_bank_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [PixW-1:0]  wr_data_i,
  input  logic             rd_en_i,
  input  logic             rd_bank_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [PixW-1:0]  rd_data_o
);

  logic [PixW-1:0] bank0_q [Depth];
  logic [PixW-1:0] bank1_q [Depth];
  logic [PixW-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      if (wr_bank_i) begin
        bank1_q[wr_addr_i] <= wr_data_i;
      end else begin
        bank0_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

  // Read data only moves on rd_en_i, so it doubles as a one-entry holding stage.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_q <= rd_bank_i ? bank1_q[rd_addr_i] : bank0_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/nn_line_upscaler.sv
// Nearest-neighbour upscaler: ping-pong row banks, each row replayed SCALE x SCALE times.
// Define UPSCALE_FRAME_MARKERS_EN to add the out_sol/out_eol/out_eof framing outputs.
module nn_line_upscaler
  import upscale_pkg::*;
#(
  parameter int unsigned IMG_W = DefImgW,
  parameter int unsigned IMG_H = DefImgH,
  parameter int unsigned SCALE = DefScale,
  parameter int unsigned PIX_W = DefPixW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [PIX_W-1:0] pixel_out,
  output logic             output_valid,
  input  logic             output_ready,
  output logic             frame_done
`ifdef UPSCALE_FRAME_MARKERS_EN
  ,
  output logic             out_sol,
  output logic             out_eol,
  output logic             out_eof
`endif
);

  localparam int unsigned ColW  = cnt_w(IMG_W - 1);
  localparam int unsigned RowW  = cnt_w(IMG_H - 1);
  localparam int unsigned RepW  = cnt_w(SCALE - 1);
  localparam int unsigned OutXW = cnt_w(IMG_W * SCALE - 1);

  localparam logic [ColW-1:0]  ColLast  = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0]  RowLast  = RowW'(IMG_H - 1);
  localparam logic [RepW-1:0]  RepLast  = RepW'(SCALE - 1);
  localparam logic [OutXW-1:0] OutXLast = OutXW'(IMG_W * SCALE - 1);

  // Input side
  logic [1:0]      full_q;
  logic            wr_bank_q;
  logic [ColW-1:0] wr_col_q;
  logic [RowW-1:0] in_row_q;
  logic            live_q;
  logic            wr_fire;

  // Output side
  emit_state_e      state_q;
  logic             rd_bank_q;
  logic [ColW-1:0]  rd_col_q;
  logic [RepW-1:0]  rd_hrep_q;
  logic [RepW-1:0]  rd_vrep_q;
  logic             rd_done_q;
  logic             a_vld_q;
  logic             out_vld_q;
  logic [PIX_W-1:0] pixel_out_q;
  logic [OutXW-1:0] out_x_q;
  logic [RepW-1:0]  out_vrep_q;
  logic [RowW-1:0]  out_row_q;
  logic             frame_done_q;
  logic [PIX_W-1:0] rd_data;

  logic xfer;
  logic b_load;
  logic rd_en;
  logic rd_last;
  logic bank_end;
  logic frame_end;

  always_comb begin
    input_ready = live_q & ~full_q[wr_bank_q];
    wr_fire     = input_valid & input_ready;
    xfer        = out_vld_q & output_ready;
    b_load      = a_vld_q & (~out_vld_q | output_ready);
    rd_en       = (state_q == StEmit) & ~rd_done_q & (~a_vld_q | b_load);
    rd_last     = (rd_col_q == ColLast) & (rd_hrep_q == RepLast) & (rd_vrep_q == RepLast);
    bank_end    = xfer & (out_x_q == OutXLast) & (out_vrep_q == RepLast);
    frame_end   = bank_end & (out_row_q == RowLast);
  end

  line_buf_2bank #(
    .Depth(IMG_W),
    .PixW (PIX_W),
    .AddrW(ColW)
  ) u_line_buf (
    .clk_i    (clk),
    .wr_en_i  (wr_fire),
    .wr_bank_i(wr_bank_q),
    .wr_addr_i(wr_col_q),
    .wr_data_i(pixel_in),
    .rd_en_i  (rd_en),
    .rd_bank_i(rd_bank_q),
    .rd_addr_i(rd_col_q),
    .rd_data_o(rd_data)
  );

  // Fill side: column/row counters, bank select and the per-bank full flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      wr_col_q  <= '0;
      in_row_q  <= '0;
      live_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (wr_fire) begin
        if (wr_col_q == ColLast) begin
          wr_col_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
          full_q[wr_bank_q] <= 1'b1;
          in_row_q  <= (in_row_q == RowLast) ? '0 : in_row_q + RowW'(1);
        end else begin
          wr_col_q <= wr_col_q + ColW'(1);
        end
      end
      // The bank being drained is always full, so it never collides with the bank being filled.
      if (bank_end) begin
        full_q[rd_bank_q] <= 1'b0;
      end
    end
  end

  // Emit side: FSM, read-issue counters, two-stage read/output pipeline, transfer counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_bank_q    <= 1'b0;
      rd_col_q     <= '0;
      rd_hrep_q    <= '0;
      rd_vrep_q    <= '0;
      rd_done_q    <= 1'b0;
      a_vld_q      <= 1'b0;
      out_vld_q    <= 1'b0;
      pixel_out_q  <= '0;
      out_x_q      <= '0;
      out_vrep_q   <= '0;
      out_row_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end;

      if (rd_en) begin
        a_vld_q <= 1'b1;
      end else if (b_load) begin
        a_vld_q <= 1'b0;
      end

      if (b_load) begin
        pixel_out_q <= rd_data;
        out_vld_q   <= 1'b1;
      end else if (xfer) begin
        out_vld_q <= 1'b0;
      end

      // One read per output pixel; the same column is re-read SCALE times.
      if (rd_en) begin
        if (rd_hrep_q != RepLast) begin
          rd_hrep_q <= rd_hrep_q + RepW'(1);
        end else begin
          rd_hrep_q <= '0;
          if (rd_col_q != ColLast) begin
            rd_col_q <= rd_col_q + ColW'(1);
          end else begin
            rd_col_q  <= '0;
            rd_vrep_q <= (rd_vrep_q == RepLast) ? '0 : rd_vrep_q + RepW'(1);
          end
        end
        if (rd_last) begin
          rd_done_q <= 1'b1;
        end
      end

      if (xfer) begin
        if (out_x_q != OutXLast) begin
          out_x_q <= out_x_q + OutXW'(1);
        end else begin
          out_x_q <= '0;
          if (out_vrep_q != RepLast) begin
            out_vrep_q <= out_vrep_q + RepW'(1);
          end else begin
            out_vrep_q <= '0;
            out_row_q  <= (out_row_q == RowLast) ? '0 : out_row_q + RowW'(1);
          end
        end
      end

      unique case (state_q)
        StIdle: begin
          if (full_q[rd_bank_q]) begin
            state_q <= StEmit;
          end
        end
        StEmit: begin
          if (bank_end) begin
            state_q <= StAdvance;
          end
        end
        StAdvance: begin
          rd_bank_q <= ~rd_bank_q;
          rd_done_q <= 1'b0;
          state_q   <= full_q[~rd_bank_q] ? StEmit : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pixel_out    = pixel_out_q;
  assign output_valid = out_vld_q;
  assign frame_done   = frame_done_q;

`ifdef UPSCALE_FRAME_MARKERS_EN
  // Markers describe the pixel currently presented on pixel_out.
  always_comb begin
    out_sol = out_vld_q & (out_x_q == '0);
    out_eol = out_vld_q & (out_x_q == OutXLast);
    out_eof = out_eol & (out_vrep_q == RepLast) & (out_row_q == RowLast);
  end
`endif

endmodule

// File: tb/tb_nn_line_upscaler.sv
// Bench for nn_line_upscaler: three geometries behind one selectable harness, checked
// against a frame-level nearest-neighbour reference model.
module tb_nn_line_upscaler;

  localparam int PW = 24;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic [PW-1:0] pin  = '0;
  logic          iv   = 1'b0;
  logic          ordy = 1'b0;
  int            sel  = 0;
  int            gw   = 4;
  int            gh   = 2;
  int            gs   = 2;
  int            geo_w [3] = '{4, 4, 384};
  int            geo_h [3] = '{2, 2, 4};
  int            geo_s [3] = '{2, 3, 1};

  logic          rdy  [3];
  logic          ov   [3];
  logic          fd   [3];
  logic [PW-1:0] pout [3];
`ifdef UPSCALE_FRAME_MARKERS_EN
  logic          sol  [3];
  logic          eol  [3];
  logic          eof  [3];
`endif

  logic          c_rdy, c_ov, c_fd;
  logic [PW-1:0] c_pout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [PW-1:0] src_q [$];
  logic [PW-1:0] exp_q [$];
  logic [PW-1:0] got_q [$];
  int            acc_n, row0_cyc, first_ov, last_cyc, fd_n, fd_cyc;
  bit            stall_pend;
  logic [PW-1:0] stall_pix;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    c_rdy  = rdy[sel];
    c_ov   = ov[sel];
    c_fd   = fd[sel];
    c_pout = pout[sel];
  end

  nn_line_upscaler #(.IMG_W(4), .IMG_H(2), .SCALE(2), .PIX_W(PW)) u_dut_s2 (
    .clk(clk), .rst(rst), .pixel_in(pin), .input_valid(iv && (sel == 0)),
    .input_ready(rdy[0]), .pixel_out(pout[0]), .output_valid(ov[0]),
    .output_ready(ordy && (sel == 0)), .frame_done(fd[0])
`ifdef UPSCALE_FRAME_MARKERS_EN
    , .out_sol(sol[0]), .out_eol(eol[0]), .out_eof(eof[0])
`endif
  );

  nn_line_upscaler #(.IMG_W(4), .IMG_H(2), .SCALE(3), .PIX_W(PW)) u_dut_s3 (
    .clk(clk), .rst(rst), .pixel_in(pin), .input_valid(iv && (sel == 1)),
    .input_ready(rdy[1]), .pixel_out(pout[1]), .output_valid(ov[1]),
    .output_ready(ordy && (sel == 1)), .frame_done(fd[1])
`ifdef UPSCALE_FRAME_MARKERS_EN
    , .out_sol(sol[1]), .out_eol(eol[1]), .out_eof(eof[1])
`endif
  );

  nn_line_upscaler #(.IMG_W(384), .IMG_H(4), .SCALE(1), .PIX_W(PW)) u_dut_s1 (
    .clk(clk), .rst(rst), .pixel_in(pin), .input_valid(iv && (sel == 2)),
    .input_ready(rdy[2]), .pixel_out(pout[2]), .output_valid(ov[2]),
    .output_ready(ordy && (sel == 2)), .frame_done(fd[2])
`ifdef UPSCALE_FRAME_MARKERS_EN
    , .out_sol(sol[2]), .out_eol(eol[2]), .out_eof(eof[2])
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    acc_n = 0; row0_cyc = -100; first_ov = -1; last_cyc = -100;
    fd_n = 0; fd_cyc = -1; stall_pend = 0;
  endtask

  task automatic set_sel(input int s);
    sel = s; gw = geo_w[s]; gh = geo_h[s]; gs = geo_s[s];
  endtask

  // Returns aligned 1 time unit after a rising edge, with the DUT ready to accept.
  task automatic do_reset();
    iv = 1'b0; ordy = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_output_valid", c_ov, 0);
    check("rst_frame_done", c_fd, 0);
    check("rst_input_ready", c_rdy, 0);
    check("rst_pixel_out", c_pout, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("input_ready_before_first_edge", c_rdy, 0);
    @(negedge clk);
    check("input_ready_after_first_edge", c_rdy, 1);
    @(posedge clk); #1;
  endtask

  // Monitor: everything is sampled mid-cycle, describing the edge that follows.
  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pend = 0;
      end else begin
        if (stall_pend) begin
          check("stall_hold_valid", c_ov, 1);
          check("stall_hold_pixel", c_pout, stall_pix);
        end
        stall_pend = c_ov && !ordy;
        stall_pix  = c_pout;
        if (c_ov && first_ov < 0) first_ov = cyc;
        if (iv && c_rdy) begin
          acc_n++;
          if (acc_n == gw) row0_cyc = cyc;
        end
        if (c_ov && ordy) begin
          got_q.push_back(c_pout);
          if (got_q.size() == exp_q.size()) last_cyc = cyc;
        end
        if (c_fd) begin
          fd_n++;
          fd_cyc = cyc;
        end
      end
    end
  end

  task automatic run_frame(input int si, input int in_mode, input int out_mode,
                           input int pix_mode, input int exp_len);
    int idx, k, nbad, fb, budget, n;
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < gw * gh; i++) begin
      src_q.push_back((pix_mode == 0) ? PW'(i + 1) : PW'($urandom));
    end
    // Reference: output (r*S+v, x) takes input (r, x/S).
    for (int r = 0; r < gh; r++)
      for (int v = 0; v < gs; v++)
        for (int x = 0; x < gw * gs; x++)
          exp_q.push_back(src_q[r * gw + x / gs]);
    clear_mon();
    budget = 10 * gw * gh * gs * gs + 200;
    idx = 0;
    k = 0;
    while (got_q.size() < exp_q.size() && k < budget) begin
      if (idx < src_q.size()) begin
        iv  = (in_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        pin = src_q[idx];
      end else begin
        iv = 1'b0;
      end
      case (out_mode)
        0:       ordy = 1'b1;
        1:       ordy = (k % 4 == 0) || (k % 4 == 3);
        default: ordy = ($urandom_range(0, 2) != 0);
      endcase
      @(negedge clk);
      if (iv && c_rdy) idx++;
      @(posedge clk); #1;
      k++;
    end
    iv = 1'b0;
    ordy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n = got_q.size();
    check($sformatf("s%0d_out_count_model", si), n, exp_q.size());
    check($sformatf("s%0d_out_count_table", si), n, exp_len);
    nbad = 0;
    fb = -1;
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        nbad++;
        if (fb < 0) fb = i;
      end
    end
    check($sformatf("s%0d_pixel_errors(first_idx=%0d)", si, fb), nbad, 0);
    check($sformatf("s%0d_frame_done_pulses", si), fd_n, 1);
    check($sformatf("s%0d_frame_done_cycle", si), fd_cyc, last_cyc + 1);
    check($sformatf("s%0d_first_valid_latency", si), first_ov, row0_cyc + 4);
    if (si == 0) begin
      check("s0_row0_second_copy_px0", got_q[8], 1);
      check("s0_row0_px7", got_q[7], 4);
      check("s0_row1_px0", got_q[16], 5);
      check("s0_last_px", got_q[31], 8);
    end
  endtask

  typedef struct {
    int sel;
    int in_mode;   // 0: always valid, 1: random gaps
    int out_mode;  // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    int pix_mode;  // 0: counting 1..N, 1: random
    int abort;     // 1: partial frame cut by a 1-cycle reset first
    int exp_len;
  } scen_t;

  scen_t scen [8];

  initial begin
    int n, k;
    bit done;
    scen[0] = '{sel: 0, in_mode: 0, out_mode: 0, pix_mode: 0, abort: 0, exp_len: 32};
    scen[1] = '{sel: 0, in_mode: 0, out_mode: 1, pix_mode: 0, abort: 0, exp_len: 32};
    scen[2] = '{sel: 0, in_mode: 1, out_mode: 2, pix_mode: 1, abort: 0, exp_len: 32};
    scen[3] = '{sel: 0, in_mode: 0, out_mode: 2, pix_mode: 1, abort: 1, exp_len: 32};
    scen[4] = '{sel: 1, in_mode: 0, out_mode: 0, pix_mode: 0, abort: 0, exp_len: 72};
    scen[5] = '{sel: 1, in_mode: 1, out_mode: 2, pix_mode: 1, abort: 0, exp_len: 72};
    scen[6] = '{sel: 2, in_mode: 0, out_mode: 0, pix_mode: 1, abort: 0, exp_len: 1536};
    scen[7] = '{sel: 2, in_mode: 1, out_mode: 2, pix_mode: 1, abort: 0, exp_len: 1536};

    for (int si = 0; si < 8; si++) begin
      set_sel(scen[si].sel);
      do_reset();
      if (scen[si].abort != 0) begin
        iv = 1'b1; ordy = 1'b1; n = 0; k = 0;
        while (n < 5 && k < 50) begin
          pin = PW'(24'hA00000 + n);
          @(negedge clk);
          if (c_rdy) n++;
          @(posedge clk); #1;
          k++;
        end
        iv = 1'b0;
        k = 0;
        while (!c_ov && k < 20) begin
          @(posedge clk); #1;
          k++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_output_valid", c_ov, 0);
        check("abort_input_ready", c_rdy, 0);
        @(posedge clk); #1;
      end
      run_frame(si, scen[si].in_mode, scen[si].out_mode, scen[si].pix_mode, scen[si].exp_len);
    end

    // Back-pressure: with output stalled both banks fill, then drain the first row set.
    set_sel(1);
    do_reset();
    exp_q.delete();
    clear_mon();
    iv = 1'b1; ordy = 1'b0; pin = PW'(24'h123456); n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (c_rdy) n++;
      @(posedge clk); #1;
    end
    check("fill_accepted_pixels", n, 8);
    @(negedge clk);
    check("fill_input_ready_low", c_rdy, 0);
    @(posedge clk); #1;
    iv = 1'b0; ordy = 1'b1; n = 0; k = 0; done = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      if (c_rdy) done = 1;
      else if (c_ov && ordy) n++;
      @(posedge clk); #1;
      k++;
    end
    check("drain_ready_returned", done, 1);
    check("drain_transfers_before_ready", n, 36);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
